// File: rtl/cblseq_pkg.sv
// cblseq_pkg: shared encodings for the microprogram sequencer.
//   op_e    : branch operation carried on CBLSEQ_Op_IN
//   MUX_*   : next-address source codes driven on CBLSEQ_MUX_OUT
package cblseq_pkg;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'b000,
    OP_JSET   = 3'b001,
    OP_JCLR   = 3'b010,
    OP_JUMP   = 3'b011,
    OP_DECODE = 3'b100,
    OP_CALL   = 3'b101,
    OP_RETURN = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  localparam logic [1:0] MUX_NEXT   = 2'b00;
  localparam logic [1:0] MUX_JUMP   = 2'b01;
  localparam logic [1:0] MUX_DECODE = 2'b10;
  localparam logic [1:0] MUX_RETURN = 2'b11;

endpackage

// File: rtl/cblseq_stack.sv
// cblseq_stack: microcall return-address LIFO.
//   clk, rst        : clock, async active-high reset (clears pointer only)
//   push, push_data : write push_data on top (ignored when full)
//   pop             : discard top (ignored when empty)
//   top             : current top entry (undefined when empty)
//   empty, full     : registered pointer decodes
module cblseq_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [IW-1:0] top_idx;

  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == PW'(DEPTH));
  // Wraps to the last slot when empty; top is not meaningful then.
  assign top_idx = ptr_q[IW-1:0] - IW'(1);
  assign top     = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full)      ptr_d = ptr_q + PW'(1);
    else if (pop && !empty) ptr_d = ptr_q - PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Storage is not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[ptr_q[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cbl_sequencer.sv
// cbl_sequencer: microprogram address sequencer with conditional branch,
// opcode dispatch and optional microcall return stack.
// Build option: define CBLSEQ_RETURN_STACK_EN to enable CALL/RETURN via the
// return stack; otherwise CALL behaves as JUMP and RETURN as NEXT.
// Ports:
//   CBLSEQ_CLOCK_50       : clock, rising edge
//   CBLSEQ_RESET_InHigh   : async active-high reset
//   CBLSEQ_Enable_IN      : advance enable (low = stall)
//   CBLSEQ_FLAGs_IN       : condition flags
//   CBLSEQ_IR13_IN        : extra test input, selected by Sel == FLAGS_WIDTH
//   CBLSEQ_Op_IN          : branch operation (op_e)
//   CBLSEQ_Sel_IN         : test select
//   CBLSEQ_JumpAddr_IN    : jump/call target
//   CBLSEQ_DecodeAddr_IN  : dispatch target
//   CBLSEQ_uAddr_OUT      : registered microaddress
//   CBLSEQ_MUX_OUT        : combinational source select
//   CBLSEQ_StackEmpty_OUT / StackFull_OUT / Error_OUT : stack status
module cbl_sequencer
  import cblseq_pkg::*;
#(
  parameter int FLAGS_WIDTH = 4,
  parameter int ADDR_WIDTH  = 11,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter int SEL_WIDTH   = $clog2(FLAGS_WIDTH + 1)
) (
  input  logic                   CBLSEQ_CLOCK_50,
  input  logic                   CBLSEQ_RESET_InHigh,
  input  logic                   CBLSEQ_Enable_IN,
  input  logic [FLAGS_WIDTH-1:0] CBLSEQ_FLAGs_IN,
  input  logic                   CBLSEQ_IR13_IN,
  input  logic [2:0]             CBLSEQ_Op_IN,
  input  logic [SEL_WIDTH-1:0]   CBLSEQ_Sel_IN,
  input  logic [ADDR_WIDTH-1:0]  CBLSEQ_JumpAddr_IN,
  input  logic [ADDR_WIDTH-1:0]  CBLSEQ_DecodeAddr_IN,
  output logic [ADDR_WIDTH-1:0]  CBLSEQ_uAddr_OUT,
  output logic [1:0]             CBLSEQ_MUX_OUT,
  output logic                   CBLSEQ_StackEmpty_OUT,
  output logic                   CBLSEQ_StackFull_OUT,
  output logic                   CBLSEQ_Error_OUT
);

  op_e                  op;
  logic                 test;
  logic [1:0]           mux_sel;
  logic [ADDR_WIDTH-1:0] uaddr_q, uaddr_d, addr_inc, addr_nxt, stk_top;
  logic                 stk_empty, stk_full;

  assign op       = op_e'(CBLSEQ_Op_IN);
  assign addr_inc = uaddr_q + ADDR_WIDTH'(1);

  // Selected test bit; out-of-range selects read as constant 0.
  always_comb begin
    test = 1'b0;
    for (int i = 0; i < FLAGS_WIDTH; i++)
      if (CBLSEQ_Sel_IN == SEL_WIDTH'(i)) test = CBLSEQ_FLAGs_IN[i];
    if (CBLSEQ_Sel_IN == SEL_WIDTH'(FLAGS_WIDTH)) test = CBLSEQ_IR13_IN;
  end

`ifdef CBLSEQ_RETURN_STACK_EN
  logic err_q, err_d, push, pop;

  // Overflowing CALL and underflowing RETURN fall back to NEXT.
  always_comb begin
    mux_sel = MUX_NEXT;
    unique case (op)
      OP_JSET:   mux_sel = test  ? MUX_JUMP : MUX_NEXT;
      OP_JCLR:   mux_sel = !test ? MUX_JUMP : MUX_NEXT;
      OP_JUMP:   mux_sel = MUX_JUMP;
      OP_DECODE: mux_sel = MUX_DECODE;
      OP_CALL:   mux_sel = stk_full  ? MUX_NEXT : MUX_JUMP;
      OP_RETURN: mux_sel = stk_empty ? MUX_NEXT : MUX_RETURN;
      default:   mux_sel = MUX_NEXT;
    endcase
  end

  assign push  = CBLSEQ_Enable_IN && (op == OP_CALL);
  assign pop   = CBLSEQ_Enable_IN && (op == OP_RETURN);
  assign err_d = err_q || (push && stk_full) || (pop && stk_empty);

  always_ff @(posedge CBLSEQ_CLOCK_50 or posedge CBLSEQ_RESET_InHigh) begin
    if (CBLSEQ_RESET_InHigh) err_q <= 1'b0;
    else                     err_q <= err_d;
  end

  cblseq_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_stack (
    .clk       (CBLSEQ_CLOCK_50),
    .rst       (CBLSEQ_RESET_InHigh),
    .push      (push),
    .pop       (pop),
    .push_data (addr_inc),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  assign CBLSEQ_Error_OUT = err_q;
`else
  always_comb begin
    mux_sel = MUX_NEXT;
    unique case (op)
      OP_JSET:   mux_sel = test  ? MUX_JUMP : MUX_NEXT;
      OP_JCLR:   mux_sel = !test ? MUX_JUMP : MUX_NEXT;
      OP_JUMP:   mux_sel = MUX_JUMP;
      OP_DECODE: mux_sel = MUX_DECODE;
      OP_CALL:   mux_sel = MUX_JUMP;
      default:   mux_sel = MUX_NEXT;
    endcase
  end

  assign stk_top          = '0;
  assign stk_empty        = 1'b1;
  assign stk_full         = 1'b0;
  assign CBLSEQ_Error_OUT = 1'b0;
`endif

  always_comb begin
    unique case (mux_sel)
      MUX_JUMP:   addr_nxt = CBLSEQ_JumpAddr_IN;
      MUX_DECODE: addr_nxt = CBLSEQ_DecodeAddr_IN;
      MUX_RETURN: addr_nxt = stk_top;
      default:    addr_nxt = addr_inc;
    endcase
    uaddr_d = CBLSEQ_Enable_IN ? addr_nxt : uaddr_q;
  end

  always_ff @(posedge CBLSEQ_CLOCK_50 or posedge CBLSEQ_RESET_InHigh) begin
    if (CBLSEQ_RESET_InHigh) uaddr_q <= ADDR_WIDTH'(RESET_ADDR);
    else                     uaddr_q <= uaddr_d;
  end

  assign CBLSEQ_uAddr_OUT      = uaddr_q;
  assign CBLSEQ_MUX_OUT        = mux_sel;
  assign CBLSEQ_StackEmpty_OUT = stk_empty;
  assign CBLSEQ_StackFull_OUT  = stk_full;

endmodule

// File: tb/tb_cbl_sequencer.sv
// tb_cbl_sequencer: directed literal checks plus randomized traffic, compared
// every cycle against a queue-based model of the sequencer.
module tb_cbl_sequencer;

  localparam int FW    = 4;
  localparam int AW    = 11;
  localparam int DEPTH = 4;
  localparam int RADDR = 0;
  localparam int SW    = $clog2(FW + 1);
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [FW-1:0] flags = '0;
  logic          ir13 = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [SW-1:0] sel = '0;
  logic [AW-1:0] jaddr = '0, daddr = '0;
  logic [AW-1:0] uaddr;
  logic [1:0]    mux;
  logic          s_empty, s_full, s_err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model state
  int m_ua;
  int m_stk[$];
  bit m_err;

  cbl_sequencer #(
    .FLAGS_WIDTH (FW),
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (RADDR)
  ) dut (
    .CBLSEQ_CLOCK_50       (clk),
    .CBLSEQ_RESET_InHigh   (rst),
    .CBLSEQ_Enable_IN      (en),
    .CBLSEQ_FLAGs_IN       (flags),
    .CBLSEQ_IR13_IN        (ir13),
    .CBLSEQ_Op_IN          (op),
    .CBLSEQ_Sel_IN         (sel),
    .CBLSEQ_JumpAddr_IN    (jaddr),
    .CBLSEQ_DecodeAddr_IN  (daddr),
    .CBLSEQ_uAddr_OUT      (uaddr),
    .CBLSEQ_MUX_OUT        (mux),
    .CBLSEQ_StackEmpty_OUT (s_empty),
    .CBLSEQ_StackFull_OUT  (s_full),
    .CBLSEQ_Error_OUT      (s_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_test();
    int s = int'(sel);
    if (s < FW)  return flags[s];
    if (s == FW) return ir13;
    return 1'b0;
  endfunction

`ifdef CBLSEQ_RETURN_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  // Expected source code: 0 next, 1 jump, 2 decode, 3 return
  function automatic int m_src();
    case (op)
      3'd1: return m_test() ? 1 : 0;
      3'd2: return m_test() ? 0 : 1;
      3'd3: return 1;
      3'd4: return 2;
      3'd5: return (STK && m_stk.size() == DEPTH) ? 0 : 1;
      3'd6: return (STK && m_stk.size() > 0) ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ua = RADDR;
      m_stk.delete();
      m_err = 1'b0;
    end else if (en) begin
      int src;
      int nxt;
      src = m_src();
      nxt = (m_ua + 1) & AMASK;
      if (STK && op == 3'd5) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(nxt);
      end
      if (STK && op == 3'd6 && m_stk.size() == 0) m_err = 1'b1;
      case (src)
        1: m_ua = int'(jaddr);
        2: m_ua = int'(daddr);
        3: m_ua = m_stk.pop_back();
        default: m_ua = nxt;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("uaddr", int'(uaddr), m_ua);
      chk("mux", int'(mux), m_src());
      chk("empty", int'(s_empty), STK ? int'(m_stk.size() == 0) : 1);
      chk("full", int'(s_full), STK ? int'(m_stk.size() == DEPTH) : 0);
      chk("error", int'(s_err), int'(m_err));
    end
  end

  task automatic apply(input bit e, input int o, input int s, input int f,
                       input int j, input int d);
    en = e; op = 3'(o); sel = SW'(s); flags = FW'(f);
    jaddr = AW'(j); daddr = AW'(d);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_uaddr", int'(uaddr), RADDR);
    chk("rst_empty", int'(s_empty), 1);
    chk("rst_full", int'(s_full), 0);
    chk("rst_error", int'(s_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // NEXT x3
    for (int i = 1; i <= 3; i++) begin
      apply(1, 0, 0, 0, 0, 0);
      chk("next_mux", int'(mux), 0);
      tick();
      chk("next_uaddr", int'(uaddr), i);
    end

    // JSET / JCLR on flag 2
    apply(1, 1, 2, 4'b0100, 'h155, 0);
    chk("jset_mux", int'(mux), 1);
    tick();
    chk("jset_uaddr", int'(uaddr), 'h155);
    apply(1, 2, 2, 4'b0100, 'h155, 0);
    chk("jclr_mux", int'(mux), 0);
    tick();
    chk("jclr_uaddr", int'(uaddr), 'h156);

    // IR13 select and constant-0 select
    ir13 = 1'b1;
    apply(1, 1, FW, 0, 'h0AA, 0);
    chk("ir13_mux", int'(mux), 1);
    apply(1, 2, FW + 1, 4'hF, 'h0AA, 0);
    chk("sel_const0_mux", int'(mux), 1);
    ir13 = 1'b0;

    // DECODE
    apply(1, 4, 0, 0, 0, 'h3C3);
    chk("decode_mux", int'(mux), 2);
    tick();
    chk("decode_uaddr", int'(uaddr), 'h3C3);

    // CALL then RETURN
    apply(1, 3, 0, 0, 'h010, 0); tick();
    apply(1, 5, 0, 0, 'h200, 0); tick();
    chk("call_uaddr", int'(uaddr), 'h200);
    apply(1, 6, 0, 0, 0, 0); tick();
    chk("ret_uaddr", int'(uaddr), STK ? 'h011 : 'h201);
    chk("ret_empty", int'(s_empty), 1);

    // wrap, RETURN while empty, stall
    apply(1, 3, 0, 0, 'h7FF, 0); tick();
    apply(1, 0, 0, 0, 0, 0); tick();
    chk("wrap_uaddr", int'(uaddr), 0);
    apply(1, 6, 0, 0, 0, 0);
    chk("ret_empty_mux", int'(mux), 0);
    tick();
    chk("ret_empty_uaddr", int'(uaddr), 1);
    chk("ret_empty_err", int'(s_err), STK ? 1 : 0);
    for (int o = 0; o < 8; o++) begin
      apply(0, o, 0, 4'hF, 'h123, 'h321); tick();
      chk("stall_uaddr", int'(uaddr), 1);
    end

    // five CALLs then four RETURNs
    apply(1, 3, 0, 0, 'h020, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      apply(1, 5, 0, 0, i * 'h100, 0); tick();
      if (i == 4) chk("call4_full", int'(s_full), STK ? 1 : 0);
    end
    chk("call5_uaddr", int'(uaddr), STK ? 'h401 : 'h500);
    chk("call5_err", int'(s_err), STK ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      int exp_r[4] = '{'h301, 'h201, 'h101, 'h021};
      apply(1, 6, 0, 0, 0, 0); tick();
      if (STK) chk("unwind_uaddr", int'(uaddr), exp_r[i]);
    end
    chk("unwind_empty", int'(s_empty), 1);

    // async reset between edges during a CALL sequence
    apply(1, 5, 0, 0, 'h444, 0); tick();
    apply(1, 5, 0, 0, 'h555, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_uaddr", int'(uaddr), RADDR);
    chk("arst_empty", int'(s_empty), 1);
    chk("arst_full", int'(s_full), 0);
    chk("arst_err", int'(s_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ir13 = 1'($urandom);
      apply(($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, (1 << SW) - 1)), int'($urandom),
            int'($urandom & AMASK), int'($urandom & AMASK));
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cbl_sequencer.md
CBL_SEQUENCER -- requirements
Module: cbl_sequencer

Interface
REQ-001 SHALL have parameter FLAGS_WIDTH, default 4, number of condition flags tested.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, microstore address width.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, microcall return-stack entries (power of two, 2..16).
REQ-004 SHALL have parameter RESET_ADDR, default 0, microaddress loaded at reset.
REQ-005 SHALL have derived SEL_WIDTH = $clog2(FLAGS_WIDTH+1).
REQ-006 SHALL have port CBLSEQ_CLOCK_50, input, 1, sole clock; rising edge.
REQ-007 SHALL have port CBLSEQ_RESET_InHigh, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port CBLSEQ_Enable_IN, input, 1, advance enable; low = stall.
REQ-009 SHALL have port CBLSEQ_FLAGs_IN, input, FLAGS_WIDTH, condition flags.
REQ-010 SHALL have port CBLSEQ_IR13_IN, input, 1, instruction bit 13 test input.
REQ-011 SHALL have port CBLSEQ_Op_IN, input, 3, branch operation.
REQ-012 SHALL have port CBLSEQ_Sel_IN, input, SEL_WIDTH, test select: 0..FLAGS_WIDTH-1 = flag index, FLAGS_WIDTH = IR13, larger = constant 0.
REQ-013 SHALL have port CBLSEQ_JumpAddr_IN, input, ADDR_WIDTH, jump/call target.
REQ-014 SHALL have port CBLSEQ_DecodeAddr_IN, input, ADDR_WIDTH, opcode-derived dispatch target.
REQ-015 SHALL have port CBLSEQ_uAddr_OUT, output, ADDR_WIDTH, registered current microaddress.
REQ-016 SHALL have port CBLSEQ_MUX_OUT, output, 2, combinational source select: 00 Next, 01 Jump, 10 Decode, 11 Return.
REQ-017 SHALL have ports CBLSEQ_StackEmpty_OUT, CBLSEQ_StackFull_OUT, CBLSEQ_Error_OUT, output, 1 each.

Function
REQ-018 Op encoding SHALL be: 000 NEXT, 001 JSET (jump if selected test = 1), 010 JCLR (jump if selected test = 0), 011 JUMP, 100 DECODE, 101 CALL, 110 RETURN, 111 reserved = NEXT.
REQ-019 Next address SHALL be Next = uAddr+1 mod 2^ADDR_WIDTH (wrap from all-ones to 0), Jump = JumpAddr, Decode = DecodeAddr, Return = stack top.
REQ-020 CBLSEQ_MUX_OUT SHALL reflect the source chosen from current inputs, same cycle, independent of Enable.
REQ-021 On a rising edge with Enable=1, uAddr SHALL load the selected next address; latency one cycle.
REQ-022 With Enable=0, uAddr, stack contents, pointer and Error SHALL hold.
REQ-023 CALL SHALL push uAddr+1 (wrapped) and jump to JumpAddr in the same edge.
REQ-024 RETURN SHALL pop and load the popped address in the same edge.
REQ-025 CALL while full SHALL perform NEXT, leave stack unchanged, and set Error.
REQ-026 RETURN while empty SHALL perform NEXT and set Error.
REQ-027 Error SHALL be sticky until reset.
REQ-028 StackEmpty/StackFull SHALL be registered-pointer decodes (pointer 0 / pointer STACK_DEPTH).

Reset
REQ-029 Reset SHALL force uAddr=RESET_ADDR, pointer=0, Error=0 immediately and asynchronously.
REQ-030 Reset SHALL force StackEmpty=1, StackFull=0; stack contents are don't-care.
REQ-031 Reset asserted mid-CALL/RETURN SHALL discard the operation.

Configuration
REQ-032 Macro CBLSEQ_RETURN_STACK_EN defined SHALL enable REQ-023..028 behaviour.
REQ-033 Without the macro: CALL SHALL act as JUMP; RETURN as NEXT with MUX_OUT=00; StackEmpty=1, StackFull=0, Error=0 constant; no stack storage inferred.

Structure
REQ-034 Package cblseq_pkg SHALL hold the Op encodings and the MUX_OUT select constants.
REQ-035 The LIFO SHALL be sub-module cblseq_stack (push, pop, top, empty, full), instantiated only under the macro.

Verification
REQ-036 Reset, Op=NEXT x3, Enable=1 from RESET_ADDR=0 -> uAddr 1,2,3; MUX_OUT=00.
REQ-037 FLAGs=4'b0100, Op=JSET, Sel=2, JumpAddr=0x155 -> MUX_OUT=01, uAddr=0x155 next edge; same with Op=JCLR -> uAddr+1.
REQ-038 uAddr=0x010, CALL JumpAddr=0x200, then RETURN -> uAddr 0x200 then 0x011, StackEmpty=1 afterwards.
REQ-039 Five CALLs with STACK_DEPTH=4 -> StackFull=1 after fourth; fifth gives uAddr+1, Error=1; four RETURNs unwind in LIFO order.
REQ-040 uAddr=0x7FF, Op=NEXT -> uAddr=0x000; RETURN while empty -> Error=1; Enable=0 any Op -> uAddr holds.
REQ-041 Reset asserted between edges during CALL sequence -> uAddr=RESET_ADDR, StackEmpty=1, Error=0 without a clock edge.
